conv_window_gen: RTL and testbench

Upstream feeder for conv_neuron. Accepts a raster-order pixel stream, one 8-bit pixel per handshake. Buffers one image row and emits every stride-1 2x2 window as a packed [3:0][7:0] word, ready to drive conv_neuron's pixels input. Output is a registered valid/ready stage so the convolution side can stall the stream.

---
 rtl/conv_pkg.sv | 19 +
 rtl/conv_line_buffer.sv | 25 ++
 rtl/conv_window_gen.sv | 120 ++++++++++++
 tb/tb_conv_window_gen.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared pixel/window types and tap ordering for the 2x2 convolution path.
// conv_neuron imports the same tap indices so both ends agree on window layout.
package conv_pkg;
    localparam int PIX_W  = 8;
    localparam int N_TAPS = 4;

    typedef logic [PIX_W-1:0]              pixel_t;
    typedef logic [N_TAPS-1:0][PIX_W-1:0]  window_t;

    localparam int TAP_TL = 3;
    localparam int TAP_TR = 2;
    localparam int TAP_BL = 1;
    localparam int TAP_BR = 0;

    typedef enum logic {
        S_ROW0   = 1'b0,
        S_STREAM = 1'b1
    } state_t;
endpackage

// File: rtl/conv_line_buffer.sv
// One-row pixel store: single address, combinational read, write on enable.
// Read returns the old contents in the cycle the same address is written.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          i_clk,
    input  logic [AW-1:0] i_addr,
    input  logic          i_wr_en,
    input  pixel_t        i_wr_data,
    output pixel_t        o_rd_data
);
    pixel_t r_mem [DEPTH];

    assign o_rd_data = r_mem[i_addr];

    // Contents are deliberately not reset: every entry is written in row 0 before it is read.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_addr] <= i_wr_data;
        end
    end
endmodule

// File: rtl/conv_window_gen.sv
// Raster pixel stream to stride-1 2x2 windows, with a registered valid/ready output stage.
// state    | meaning
// S_ROW0   | filling the first row of a frame, no windows emitted
// S_STREAM | rows 1..H-1, a window is emitted for every pixel with col >= 1
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int  IMG_WIDTH  = 8,
    parameter int  IMG_HEIGHT = 8,
    localparam int CW         = $clog2(IMG_WIDTH),
    localparam int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  pixel_t        i_in_pixel,
    output logic          o_win_valid,
    input  logic          i_win_ready,
    output window_t       o_pixels,
    output logic [RW-1:0] o_win_row,
    output logic [CW-1:0] o_win_col,
    output logic          o_frame_done
);
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    pixel_t        r_prev_cur;
    pixel_t        r_prev_top;
    logic          r_win_valid;
    window_t       r_pixels;
    logic [RW-1:0] r_win_row;
    logic [CW-1:0] r_win_col;
    logic          r_frame_done;

    logic          w_acc;
    logic          w_last_col;
    logic          w_last_row;
    logic          w_win_gen;
    pixel_t        w_top;

    assign o_in_ready = !r_win_valid | i_win_ready;
    assign w_acc      = i_in_valid & o_in_ready;
    assign w_last_col = (r_col == CW'(IMG_WIDTH - 1));
    assign w_last_row = (r_row == RW'(IMG_HEIGHT - 1));
    assign w_win_gen  = w_acc & (r_state == S_STREAM) & (r_col != '0);

    conv_line_buffer #(
        .DEPTH (IMG_WIDTH)
    ) u_line_buffer (
        .i_clk     (i_clk),
        .i_addr    (r_col),
        .i_wr_en   (w_acc),
        .i_wr_data (i_in_pixel),
        .o_rd_data (w_top)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_ROW0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ROW0:   if (w_acc && w_last_col)               w_state_nxt = S_STREAM;
            S_STREAM: if (w_acc && w_last_col && w_last_row) w_state_nxt = S_ROW0;
            default:                                          w_state_nxt = S_ROW0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_col        <= '0;
            r_row        <= '0;
            r_prev_cur   <= '0;
            r_prev_top   <= '0;
            r_win_valid  <= 1'b0;
            r_pixels     <= '0;
            r_win_row    <= '0;
            r_win_col    <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_acc) begin
                r_prev_cur <= i_in_pixel;
                r_prev_top <= w_top;
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A fresh window always wins over a drain in the same cycle.
            if (w_win_gen) begin
                r_pixels[TAP_TL] <= r_prev_top;
                r_pixels[TAP_TR] <= w_top;
                r_pixels[TAP_BL] <= r_prev_cur;
                r_pixels[TAP_BR] <= i_in_pixel;
                r_win_row        <= r_row;
                r_win_col        <= r_col;
                r_win_valid      <= 1'b1;
                r_frame_done     <= w_last_row & w_last_col;
            end else if (r_win_valid && i_win_ready) begin
                r_win_valid  <= 1'b0;
                r_frame_done <= 1'b0;
            end
        end
    end

    assign o_win_valid  = r_win_valid;
    assign o_pixels     = r_pixels;
    assign o_win_row    = r_win_row;
    assign o_win_col    = r_win_col;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x3 image with a scoreboard of expected windows.
module tb_conv_window_gen;
    import conv_pkg::*;

    localparam int W = 4;
    localparam int H = 3;

    typedef struct packed {
        window_t    pix;
        logic [1:0] row;
        logic [1:0] col;
        logic       fd;
    } win_t;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_in_valid;
    logic       o_in_ready;
    pixel_t     i_in_pixel;
    logic       o_win_valid;
    logic       i_win_ready;
    window_t    o_pixels;
    logic [1:0] o_win_row;
    logic [1:0] o_win_col;
    logic       o_frame_done;

    win_t   sb[$];
    win_t   got[$];
    pixel_t img [H][W];
    int     mr, mc;
    int     n_checks = 0;
    int     n_pass   = 0;
    win_t   mon_act, mon_exp;
    window_t exp1 [6];

    conv_window_gen #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_pixel   (i_in_pixel),
        .o_win_valid  (o_win_valid),
        .i_win_ready  (i_win_ready),
        .o_pixels     (o_pixels),
        .o_win_row    (o_win_row),
        .o_win_col    (o_win_col),
        .o_frame_done (o_frame_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_accept(input pixel_t pix);
        win_t e;
        img[mr][mc] = pix;
        if (mr >= 1 && mc >= 1) begin
            e.pix = {img[mr-1][mc-1], img[mr-1][mc], img[mr][mc-1], pix};
            e.row = 2'(mr);
            e.col = 2'(mc);
            e.fd  = (mr == H-1) && (mc == W-1);
            sb.push_back(e);
        end
        if (mc == W-1) begin
            mc = 0;
            mr = (mr == H-1) ? 0 : mr + 1;
        end else begin
            mc = mc + 1;
        end
    endfunction

    // Every window that is valid and ready at this point transfers on the next rising edge.
    always @(negedge i_clk) begin
        #2;
        if (!i_rst && o_win_valid && i_win_ready) begin
            mon_act = '{o_pixels, o_win_row, o_win_col, o_frame_done};
            got.push_back(mon_act);
            chk("sb_has_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                chk("win_pixels", mon_act.pix, mon_exp.pix);
                chk("win_row", 32'(mon_act.row), 32'(mon_exp.row));
                chk("win_col", 32'(mon_act.col), 32'(mon_exp.col));
                chk("frame_done", 32'(mon_act.fd), 32'(mon_exp.fd));
            end
        end
    end

    task automatic send(input pixel_t pix);
        int   budget;
        logic acc;
        budget = 0;
        acc    = 1'b0;
        i_in_valid = 1'b1;
        i_in_pixel = pix;
        while (!acc && budget < 40) begin
            #1;
            acc = o_in_ready;
            @(posedge i_clk);
            if (acc) model_accept(pix);
            @(negedge i_clk);
            budget++;
        end
        i_in_valid = 1'b0;
        chk("pixel_accepted", 32'(acc), 32'd1);
    endtask

    task automatic drain();
        int b;
        b = 0;
        while (sb.size() != 0 && b < 30) begin
            @(negedge i_clk);
            b++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        @(negedge i_clk);
        #1;
        chk("idle_win_valid", 32'(o_win_valid), 32'd0);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        sb.delete();
        mr = 0;
        mc = 0;
        @(negedge i_clk);
        i_rst = 1'b0;
        #1;
        chk("rst_win_valid", 32'(o_win_valid), 32'd0);
        chk("rst_frame_done", 32'(o_frame_done), 32'd0);
    endtask

    task automatic check_frame1(input string tag);
        int nfd;
        nfd = 0;
        chk({tag, "_count"}, 32'(got.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < got.size()) begin
                chk({tag, "_win"}, got[i].pix, exp1[i]);
                if (got[i].fd) nfd++;
            end
        end
        chk({tag, "_fd_count"}, 32'(nfd), 32'd1);
        if (got.size() == 6) begin
            chk({tag, "_last_fd"}, 32'(got[5].fd), 32'd1);
            chk({tag, "_last_row"}, 32'(got[5].row), 32'd2);
            chk({tag, "_last_col"}, 32'(got[5].col), 32'd3);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nfd;
        exp1[0] = {8'd1, 8'd2, 8'd5,  8'd6};
        exp1[1] = {8'd2, 8'd3, 8'd6,  8'd7};
        exp1[2] = {8'd3, 8'd4, 8'd7,  8'd8};
        exp1[3] = {8'd5, 8'd6, 8'd9,  8'd10};
        exp1[4] = {8'd6, 8'd7, 8'd10, 8'd11};
        exp1[5] = {8'd7, 8'd8, 8'd11, 8'd12};
        mr = 0;
        mc = 0;
        i_rst       = 1'b1;
        i_in_valid  = 1'b0;
        i_in_pixel  = '0;
        i_win_ready = 1'b1;
        repeat (2) @(negedge i_clk);
        #1;
        chk("reset_win_valid", 32'(o_win_valid), 32'd0);
        chk("reset_pixels", o_pixels, 32'd0);
        chk("reset_win_row", 32'(o_win_row), 32'd0);
        chk("reset_win_col", 32'(o_win_col), 32'd0);
        chk("reset_frame_done", 32'(o_frame_done), 32'd0);
        chk("reset_in_ready", 32'(o_in_ready), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b0;

        // Plain stream, downstream always ready.
        got.delete();
        for (int p = 1; p <= 12; p++) send(pixel_t'(p));
        drain();
        check_frame1("s1");

        // Downstream stalls for three cycles on the first window.
        got.delete();
        i_win_ready = 1'b0;
        for (int p = 1; p <= 6; p++) send(pixel_t'(p));
        i_in_valid = 1'b1;
        i_in_pixel = 8'd7;
        repeat (3) begin
            #1;
            chk("stall_win_valid", 32'(o_win_valid), 32'd1);
            chk("stall_pixels", o_pixels, 32'h01020506);
            chk("stall_in_ready", 32'(o_in_ready), 32'd0);
            @(negedge i_clk);
        end
        i_win_ready = 1'b1;
        for (int p = 7; p <= 12; p++) send(pixel_t'(p));
        drain();
        check_frame1("s2");

        // in_valid alternating with idle cycles.
        got.delete();
        for (int p = 1; p <= 12; p++) begin
            send(pixel_t'(p));
            @(negedge i_clk);
            #1;
            chk("gap_win_valid", 32'(o_win_valid), 32'd0);
        end
        drain();
        check_frame1("s3");

        // Two frames back to back.
        got.delete();
        for (int p = 1; p <= 12; p++) send(pixel_t'(p));
        for (int p = 101; p <= 112; p++) send(pixel_t'(p));
        drain();
        chk("b2b_count", 32'(got.size()), 32'd12);
        nfd = 0;
        foreach (got[i]) if (got[i].fd) nfd++;
        chk("b2b_fd_count", 32'(nfd), 32'd2);
        if (got.size() == 12) begin
            chk("b2b_f2_first", got[6].pix, 32'h6566696a);
            chk("b2b_f1_last_fd", 32'(got[5].fd), 32'd1);
            chk("b2b_f2_last", got[11].pix, 32'h6b6c6f70);
        end

        // Reset mid-frame after pixel 7, then a clean frame.
        got.delete();
        for (int p = 1; p <= 7; p++) send(pixel_t'(p));
        do_reset();
        got.delete();
        for (int p = 1; p <= 12; p++) send(pixel_t'(p));
        drain();
        check_frame1("s5");

        // Alternating extreme values pass through unchanged.
        got.delete();
        for (int i = 0; i < 12; i++) send((i % 2 == 1) ? 8'h01 : 8'hff);
        drain();
        chk("alt_count", 32'(got.size()), 32'd6);
        if (got.size() >= 2) begin
            chk("alt_first", got[0].pix, 32'hff01ff01);
            chk("alt_second", got[1].pix, 32'h01ff01ff);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
